// File: rtl/cdb_arbiter.sv
// Purpose : arbitrates ALU and SLB results onto the single common data bus (CDB).
// Latency : a result accepted at edge E is broadcast after edge E+1 at the earliest.
// Backpressure: each source has a one-entry hold; ready = hold empty or draining this cycle.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   flush               ROB mispredict/exception flush, drops held and broadcast results
//   alu_valid/data/tag  ALU result request, alu_ready accepts it
//   slb_valid/data/tag  SLB result request, slb_ready accepts it
//   cdb_valid/data/tag  registered broadcast to the ROB and to RS/SLB wakeup
//   cdb_src             registered source of the broadcast (0 = ALU, 1 = SLB)
//
// Build option: define CDB_RR_EN for round-robin tie breaking. Without it the
// SLB always wins ties (loads complete first) and the ALU can be starved.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [TAG_W-1:0]  alu_tag,
  output logic              alu_ready,
  input  logic              slb_valid,
  input  logic [DATA_W-1:0] slb_data,
  input  logic [TAG_W-1:0]  slb_tag,
  output logic              slb_ready,
  output logic              cdb_valid,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic              cdb_src
);

  logic              alu_hold_v;
  logic [DATA_W-1:0] alu_hold_data;
  logic [TAG_W-1:0]  alu_hold_tag;
  logic              slb_hold_v;
  logic [DATA_W-1:0] slb_hold_data;
  logic [TAG_W-1:0]  slb_hold_tag;

  // prio: 0 = ALU favoured on a tie, 1 = SLB favoured.
  logic prio;
  logic alu_win;
  logic slb_win;
  logic alu_take;
  logic slb_take;

  // Grant depends only on registered holds, so ready never depends on valid.
  assign alu_win = alu_hold_v & (~slb_hold_v | ~prio);
  assign slb_win = slb_hold_v & (~alu_hold_v | prio);

  // A draining winner can be refilled on the same edge.
  assign alu_ready = ~alu_hold_v | alu_win;
  assign slb_ready = ~slb_hold_v | slb_win;

  assign alu_take = alu_valid & alu_ready;
  assign slb_take = slb_valid & slb_ready;

`ifdef CDB_RR_EN
  // After a contested grant, favour the loser; uncontested grants and flushes leave it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (!flush && alu_hold_v && slb_hold_v) begin
      prio <= alu_win;
    end
  end
`else
  assign prio = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_hold_v    <= 1'b0;
      alu_hold_data <= '0;
      alu_hold_tag  <= '0;
      slb_hold_v    <= 1'b0;
      slb_hold_data <= '0;
      slb_hold_tag  <= '0;
      cdb_valid     <= 1'b0;
      cdb_data      <= '0;
      cdb_tag       <= '0;
      cdb_src       <= 1'b0;
    end else if (flush) begin
      // Discard held results, the current broadcast and anything offered this cycle.
      alu_hold_v <= 1'b0;
      slb_hold_v <= 1'b0;
      cdb_valid  <= 1'b0;
    end else begin
      cdb_valid <= alu_win | slb_win;
      // With no winner, data/tag/src keep their last values.
      if (alu_win) begin
        cdb_data <= alu_hold_data;
        cdb_tag  <= alu_hold_tag;
        cdb_src  <= 1'b0;
      end else if (slb_win) begin
        cdb_data <= slb_hold_data;
        cdb_tag  <= slb_hold_tag;
        cdb_src  <= 1'b1;
      end

      if (alu_take) begin
        alu_hold_v    <= 1'b1;
        alu_hold_data <= alu_data;
        alu_hold_tag  <= alu_tag;
      end else if (alu_win) begin
        alu_hold_v <= 1'b0;
      end

      if (slb_take) begin
        slb_hold_v    <= 1'b1;
        slb_hold_data <= slb_data;
        slb_hold_tag  <= slb_tag;
      end else if (slb_win) begin
        slb_hold_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Purpose : self-checking bench for cdb_arbiter with a cycle-level reference model.
// Latency : model predicts the registered CDB outputs one edge after a hold is granted.
// Backpressure: stimulus only advances a source's payload once it has been accepted.
module tb_cdb_arbiter;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 3;
`ifdef CDB_RR_EN
  localparam int FAV0 = 0;
`else
  localparam int FAV0 = 1;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              alu_valid;
  logic [DATA_W-1:0] alu_data;
  logic [TAG_W-1:0]  alu_tag;
  logic              alu_ready;
  logic              slb_valid;
  logic [DATA_W-1:0] slb_data;
  logic [TAG_W-1:0]  slb_tag;
  logic              slb_ready;
  logic              cdb_valid;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  cdb_tag;
  logic              cdb_src;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_data  (alu_data),
    .alu_tag   (alu_tag),
    .alu_ready (alu_ready),
    .slb_valid (slb_valid),
    .slb_data  (slb_data),
    .slb_tag   (slb_tag),
    .slb_ready (slb_ready),
    .cdb_valid (cdb_valid),
    .cdb_data  (cdb_data),
    .cdb_tag   (cdb_tag),
    .cdb_src   (cdb_src)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each source is a one-slot mailbox; index 0 = ALU, 1 = SLB. fav names the
  // source that wins when both mailboxes are occupied.
  logic [DATA_W-1:0] pend_d [2];
  logic [TAG_W-1:0]  pend_t [2];
  bit                has    [2];
  int                fav = FAV0;
  logic              m_v = 1'b0;
  logic [DATA_W-1:0] m_d = '0;
  logic [TAG_W-1:0]  m_t = '0;
  logic              m_s = 1'b0;

  function automatic int pick();
    if (has[0] && has[1]) return fav;
    if (has[0]) return 0;
    if (has[1]) return 1;
    return -1;
  endfunction

  function automatic logic m_rdy(input int x);
    return !has[x] || (pick() == x);
  endfunction

  task automatic model_step();
    int w;
    bit both;
    if (rst) begin
      has[0] = 0; has[1] = 0;
      fav = FAV0;
      m_v = 1'b0; m_d = '0; m_t = '0; m_s = 1'b0;
    end else if (flush) begin
      has[0] = 0; has[1] = 0;
      m_v = 1'b0;
    end else begin
      w = pick();
      both = has[0] && has[1];
      if (w < 0) begin
        m_v = 1'b0;
      end else begin
        m_v = 1'b1;
        m_d = pend_d[w];
        m_t = pend_t[w];
        m_s = (w == 1);
        has[w] = 0;
`ifdef CDB_RR_EN
        if (both) fav = 1 - w;
`endif
      end
      // A mailbox that is empty after the broadcast takes a new offer.
      if (alu_valid && !has[0]) begin pend_d[0] = alu_data; pend_t[0] = alu_tag; has[0] = 1; end
      if (slb_valid && !has[1]) begin pend_d[1] = slb_data; pend_t[1] = slb_tag; has[1] = 1; end
    end
  endtask

  initial begin
    has[0] = 0; has[1] = 0;
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Single compare process, every cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    chk("cdb_valid", 64'(cdb_valid), 64'(m_v));
    chk("cdb_data",  64'(cdb_data),  64'(m_d));
    chk("cdb_tag",   64'(cdb_tag),   64'(m_t));
    chk("cdb_src",   64'(cdb_src),   64'(m_s));
    chk("alu_ready", 64'(alu_ready), 64'(m_rdy(0)));
    chk("slb_ready", 64'(slb_ready), 64'(m_rdy(1)));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_alu(input logic v, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    alu_valid = v; alu_data = d; alu_tag = t;
  endtask

  task automatic set_slb(input logic v, input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t);
    slb_valid = v; slb_data = d; slb_tag = t;
  endtask

  initial begin
    logic              f_src, s_src;
    logic [DATA_W-1:0] f_dat, s_dat;
    int na, ns, exp_a, exp_s, nbc;
    logic a_acc, s_acc, prev_src;

    rst = 1'b0; flush = 1'b0;
    set_alu(0, '0, '0);
    set_slb(0, '0, '0);
    #1 rst = 1'b1;
    #1;
    chk("reset_cdb_valid", 64'(cdb_valid), 64'(0));
    chk("reset_cdb_data",  64'(cdb_data),  64'(0));
    chk("reset_alu_ready", 64'(alu_ready), 64'(1));
    chk("reset_slb_ready", 64'(slb_ready), 64'(1));
    tick(); tick();
    rst = 1'b0;

    // Single ALU result.
    set_alu(1, 32'h0000_00AB, 3'd3);
    tick();
    set_alu(0, '0, '0);
    chk("single_e0_valid", 64'(cdb_valid), 64'(0));
    tick();
    chk("single_e1_valid", 64'(cdb_valid), 64'(1));
    chk("single_e1_data",  64'(cdb_data),  64'(32'hAB));
    chk("single_e1_tag",   64'(cdb_tag),   64'(3));
    chk("single_e1_src",   64'(cdb_src),   64'(0));
    tick();
    chk("single_e2_valid", 64'(cdb_valid), 64'(0));

    // Both requesters in the same cycle.
`ifdef CDB_RR_EN
    f_src = 1'b0; f_dat = 32'h11; s_src = 1'b1; s_dat = 32'h22;
`else
    f_src = 1'b1; f_dat = 32'h22; s_src = 1'b0; s_dat = 32'h11;
`endif
    set_alu(1, 32'h11, 3'd1);
    set_slb(1, 32'h22, 3'd2);
    tick();
    set_alu(0, '0, '0);
    set_slb(0, '0, '0);
    chk("both_loser_ready_alu", 64'(alu_ready), 64'(f_src == 1'b0));
    chk("both_loser_ready_slb", 64'(slb_ready), 64'(f_src == 1'b1));
    tick();
    chk("both_first_valid", 64'(cdb_valid), 64'(1));
    chk("both_first_src",   64'(cdb_src),   64'(f_src));
    chk("both_first_data",  64'(cdb_data),  64'(f_dat));
    chk("both_loser_ready_winning", 64'(s_src ? slb_ready : alu_ready), 64'(1));
    tick();
    chk("both_second_valid", 64'(cdb_valid), 64'(1));
    chk("both_second_src",   64'(cdb_src),   64'(s_src));
    chk("both_second_data",  64'(cdb_data),  64'(s_dat));
    tick();
    chk("both_idle_valid", 64'(cdb_valid), 64'(0));

    // Reset mid-stream: ALU still held while the SLB result is on the bus.
    set_alu(1, 32'h31, 3'd4);
    set_slb(1, 32'h41, 3'd5);
    tick();
    set_alu(0, '0, '0);
    set_slb(0, '0, '0);
    tick();
    chk("rstmid_pre_valid", 64'(cdb_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("rstmid_cdb_valid", 64'(cdb_valid), 64'(0));
    chk("rstmid_cdb_data",  64'(cdb_data),  64'(0));
    chk("rstmid_alu_ready", 64'(alu_ready), 64'(1));
    chk("rstmid_slb_ready", 64'(slb_ready), 64'(1));
    tick();
    rst = 1'b0;

    // Sustained contention for 8 cycles with incrementing payloads.
    na = 0; ns = 0; exp_a = 0; exp_s = 0; nbc = 0; prev_src = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        set_alu(1, 32'h100 + 32'(na), {1'b0, 2'(na)});
        set_slb(1, 32'h200 + 32'(ns), {1'b1, 2'(ns)});
      end else begin
        set_alu(0, '0, '0);
        set_slb(0, '0, '0);
      end
      a_acc = alu_valid & alu_ready;
      s_acc = slb_valid & slb_ready;
      tick();
      if (a_acc) na++;
      if (s_acc) ns++;
      if (cdb_valid) begin
        if (cdb_src) begin
          chk("sustain_slb_order", 64'(cdb_data), 64'(32'h200 + 32'(exp_s)));
          exp_s++;
        end else begin
          chk("sustain_alu_order", 64'(cdb_data), 64'(32'h100 + 32'(exp_a)));
          exp_a++;
        end
`ifdef CDB_RR_EN
        if (nbc > 0) chk("sustain_alternate", 64'(cdb_src), 64'(~prev_src));
`else
        if (nbc < 8) chk("sustain_slb_streams", 64'(cdb_src), 64'(1));
`endif
        prev_src = cdb_src;
        nbc++;
      end
    end
    chk("sustain_broadcasts", 64'(nbc), 64'(9));
`ifdef CDB_RR_EN
    chk("sustain_alu_count", 64'(exp_a), 64'(5));
    chk("sustain_slb_count", 64'(exp_s), 64'(4));
`else
    chk("sustain_alu_count", 64'(exp_a), 64'(1));
    chk("sustain_slb_count", 64'(exp_s), 64'(8));
`endif

    // Flush with an ALU result held and an SLB result being offered.
    set_alu(1, 32'h55, 3'd5);
    tick();
    set_alu(0, '0, '0);
    set_slb(1, 32'h66, 3'd6);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_slb(0, '0, '0);
    chk("flush_cdb_valid", 64'(cdb_valid), 64'(0));
    chk("flush_alu_ready", 64'(alu_ready), 64'(1));
    chk("flush_slb_ready", 64'(slb_ready), 64'(1));
    tick();
    chk("flush_after_valid", 64'(cdb_valid), 64'(0));

    // Back-to-back ALU results, tags 0..3.
    for (int i = 0; i < 4; i++) begin
      set_alu(1, 32'hC0 + 32'(i), 3'(i));
      chk("b2b_alu_ready", 64'(alu_ready), 64'(1));
      tick();
      if (i > 0) begin
        chk("b2b_valid", 64'(cdb_valid), 64'(1));
        chk("b2b_tag",   64'(cdb_tag),   64'(i - 1));
      end
    end
    set_alu(0, '0, '0);
    tick();
    chk("b2b_last_valid", 64'(cdb_valid), 64'(1));
    chk("b2b_last_tag",   64'(cdb_tag),   64'(3));
    tick();
    chk("b2b_idle_valid", 64'(cdb_valid), 64'(0));
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Arbitrates completed results from the ALU and the store/load buffer (SLB) onto a single common data bus (CDB) broadcast port.
- The CDB feeds the reorder buffer's result-update path and the RS/SLB operand wakeup.
- Each requester owns a one-entry holding register, so a losing requester is back-pressured rather than dropped.
- A mispredict/exception flush discards all pending and broadcast results.

Parameters:
- DATA_W, 32, width of result data.
- TAG_W, 3, width of the ROB entry tag (matches ROB pointer width).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  exception/mispredict flush from the ROB.
- alu_valid  in  1  ALU result valid.
- alu_data  in  DATA_W  ALU result.
- alu_tag  in  TAG_W  ROB tag of the ALU result.
- alu_ready  out  1  ALU result is accepted this cycle when alu_valid and alu_ready are both high.
- slb_valid  in  1  SLB result valid.
- slb_data  in  DATA_W  SLB result.
- slb_tag  in  TAG_W  ROB tag of the SLB result.
- slb_ready  out  1  SLB result is accepted this cycle when slb_valid and slb_ready are both high.
- cdb_valid  out  1  broadcast valid, registered.
- cdb_data  out  DATA_W  broadcast data, registered.
- cdb_tag  out  TAG_W  broadcast tag, registered.
- cdb_src  out  1  source of the broadcast: 0 = ALU, 1 = SLB; registered.

Behaviour:
- State:
  - Per source: hold_v, hold_data, hold_tag.
  - prio bit: 0 = ALU favoured, 1 = SLB favoured.
  - CDB output registers.
- Reset (async, rst high): all hold_v = 0, prio = 0, cdb_valid = 0, cdb_data = 0, cdb_tag = 0, cdb_src = 0.
  - alu_ready and slb_ready read 1 during and after reset (holds empty).
- Grant (combinational, from registered state only):
  - Only one hold_v set: that source wins.
  - Both set: the source named by prio wins.
  - Neither set: no grant.
- ready_x = !hold_v_x | win_x. A winner can be refilled on the same edge it drains, giving full throughput.
  - Ready has no combinational dependence on valid inputs.
- On each rising edge, no flush:
  - A winner exists: cdb_valid = 1; cdb_data, cdb_tag and cdb_src take the winner's hold; the winner's hold_v clears unless it is refilled on the same edge.
  - No winner: cdb_valid = 0; cdb_data and cdb_tag keep their last values.
  - Source x captures when valid_x & ready_x: hold_v_x = 1 with its data and tag.
- Latency: a result accepted at edge E is broadcast after edge E+1 at the earliest (cdb_valid high in the cycle following E+1).
- Throughput: one broadcast per cycle. A sustained pair of requesters gets alternating grants (see optional feature for priority update).
- Flush (synchronous, sampled at the edge, highest priority):
  - All hold_v = 0 and cdb_valid = 0.
  - Inputs presented that cycle are discarded even if ready was high.
  - prio is unchanged.
- Simultaneous flush and rst: rst dominates.
- Tag equality between sources is not checked. Tags are unique by ROB construction.
- A requester must hold valid, data and tag stable until accepted. Data changing before acceptance is a protocol violation and is not detected.

Optional Feature:
- Macro CDB_RR_EN.
- Defined: round-robin. After any grant made while both hold_v were set, prio points to the loser. Single-request grants leave prio unchanged.
- Undefined: fixed priority. prio is tied to 1 (SLB always wins ties), so loads complete first. The ALU may be starved while the SLB streams.

Test Plan:
- Reset mid-stream: assert rst while alu hold_v = 1 and cdb_valid = 1 -> cdb_valid = 0, cdb_data = 0, alu_ready = 1 immediately, without waiting for a clock edge.
- Single ALU result: alu_valid = 1, data 0x0000_00AB, tag 3 for one cycle -> accepted at E0; cdb_valid = 1, cdb_data = 0xAB, cdb_tag = 3, cdb_src = 0 after E1; cdb_valid = 0 after E2.
- Both requesters:
  - Stimulus: ALU (0x11, tag 1) and SLB (0x22, tag 2) presented in the same cycle.
  - CDB_RR_EN defined: ALU is broadcast first, then SLB in the next cycle.
  - CDB_RR_EN undefined: SLB first, then ALU.
  - In the cycle after the first broadcast, the loser's ready is 0 unless it is winning that cycle.
- Sustained contention with CDB_RR_EN: both valid continuously for 8 cycles with incrementing data -> cdb_src alternates 0,1,0,1…; no drop and no duplicate; per-source order preserved.
- Flush: hold ALU (tag 5) pending plus SLB presented, then assert flush for one edge -> no broadcast of tag 5 or the SLB data; cdb_valid = 0 after the flush edge; both ready = 1 next cycle.
- Back-to-back single source: alu_valid held high for 4 cycles with tags 0..3 -> alu_ready stays 1; the CDB shows tags 0,1,2,3 on consecutive cycles.
